mac_instruction_sequencer: RTL and testbench



---
 rtl/mac_instruction_sequencer_pkg.sv | 29 ++
 rtl/mac_instruction_sequencer_if.sv | 34 +++
 rtl/mac_instruction_sequencer_valid_delay_line.sv | 28 ++
 rtl/mac_instruction_sequencer.sv | 150 +++++++++++++++
 tb/tb_mac_instruction_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_instruction_sequencer_pkg.sv
// Shared types and constants for the MAC instruction sequencer.
// Decoded instruction layout is the one used by the instruction queue.
package mac_instruction_sequencer_pkg;

    localparam int UB_ADDR_W     = 12;
    localparam int DIM_W         = 8;
    localparam int SEQ_IQ_LAT    = 2;
    localparam int SEQ_DRAIN_LAT = 8;

    localparam logic [2:0] MAC_OP_MATMUL = 3'b010;

    typedef logic [1:0] seq_state_t;
    localparam seq_state_t S_IDLE      = 2'd0;
    localparam seq_state_t S_WAIT_HEAD = 2'd1;
    localparam seq_state_t S_ISSUE     = 2'd2;
    localparam seq_state_t S_DRAIN     = 2'd3;

    typedef struct packed {
        logic [2:0]           MAC_op;
        logic [DIM_W-1:0]     U_dim;
        logic [DIM_W-1:0]     U_dim1;
        logic [DIM_W-1:0]     ITER_dim;
        logic [DIM_W-1:0]     ITER_dim1;
        logic [DIM_W-1:0]     V_dim;
        logic [UB_ADDR_W-1:0] start_rd;
        logic [UB_ADDR_W-1:0] start_wr;
    } decoded_instr_t;

endpackage

// File: rtl/mac_instruction_sequencer_if.sv
// Queue-side and MAC/unified-buffer-side signals of the sequencer.
// master = sequencer, slave = queue plus array/buffer environment.
interface mac_instruction_sequencer_if;
    import mac_instruction_sequencer_pkg::*;

    logic                 iq_empty;
    decoded_instr_t       decoded_instruction;
    logic                 read;
    logic                 busy;
    logic [2:0]           mac_op;
    logic [DIM_W-1:0]     mac_cols;
    logic                 ub_rd_en;
    logic [UB_ADDR_W-1:0] ub_rd_addr;
    logic [DIM_W-1:0]     u_idx;
    logic [DIM_W-1:0]     iter_idx;
    logic                 ub_wr_en;
    logic [UB_ADDR_W-1:0] ub_wr_addr;
    logic                 instr_done;

    modport master (
        input  iq_empty, decoded_instruction,
        output read, busy, mac_op, mac_cols,
        output ub_rd_en, ub_rd_addr, u_idx, iter_idx,
        output ub_wr_en, ub_wr_addr, instr_done
    );

    modport slave (
        output iq_empty, decoded_instruction,
        input  read, busy, mac_op, mac_cols,
        input  ub_rd_en, ub_rd_addr, u_idx, iter_idx,
        input  ub_wr_en, ub_wr_addr, instr_done
    );

endinterface

// File: rtl/mac_instruction_sequencer_valid_delay_line.sv
// DEPTH-stage valid shift register with synchronous clear.
// any_valid_o reports whether any beat is still held after this cycle's shift.
module valid_delay_line #(
    parameter int DEPTH = 8
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic valid_i,
    output logic valid_o,
    output logic any_valid_o
);

    logic [DEPTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) pipe_q <= '0;
        else       pipe_q <= pipe_d;
    end

    assign valid_o     = pipe_q[DEPTH-1];
    assign any_valid_o = |pipe_d;

endmodule

// File: rtl/mac_instruction_sequencer.sv
// Pops decoded instructions, streams unified-buffer read beats over U x ITER
// and emits matching write-back beats DRAIN_LAT cycles later.
module mac_instruction_sequencer
    import mac_instruction_sequencer_pkg::*;
#(
    parameter int IQ_LAT    = SEQ_IQ_LAT,
    parameter int DRAIN_LAT = SEQ_DRAIN_LAT
) (
    input  logic clk_i,
    input  logic rst_i,
    mac_instruction_sequencer_if.master bus
);

    localparam int CW = (IQ_LAT > 1) ? $clog2(IQ_LAT) : 1;

    seq_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           mac_op_q, mac_op_d;
    logic [DIM_W-1:0]     cols_q, cols_d;
    logic [DIM_W-1:0]     u_last_q, u_last_d;
    logic [DIM_W-1:0]     it_last_q, it_last_d;
    logic [DIM_W-1:0]     u_q, u_d, it_q, it_d;
    logic [UB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [UB_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic                 done_q, done_d;
    logic                 pop, drain_done, issue, wr_en, pending, is_mac;
    decoded_instr_t       head;

    assign head   = bus.decoded_instruction;
    assign issue  = (state_q == S_ISSUE);
    assign is_mac = (head.MAC_op == MAC_OP_MATMUL) &&
                    (head.U_dim != '0) && (head.ITER_dim != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mac_op_d   = mac_op_q;
        cols_d     = cols_q;
        u_last_d   = u_last_q;
        it_last_d  = it_last_q;
        u_d        = u_q;
        it_d       = it_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        drain_done = 1'b0;
        if (wr_en) wr_addr_d = wr_addr_q + UB_ADDR_W'(1);
        unique case (state_q)
            S_IDLE: begin
                if (!bus.iq_empty) begin
                    state_d = S_WAIT_HEAD;
                    cnt_d   = CW'(IQ_LAT - 1);
                end
            end
            S_WAIT_HEAD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (bus.iq_empty) begin
                    state_d = S_IDLE;
                end else begin
                    pop       = 1'b1;
                    mac_op_d  = head.MAC_op;
                    cols_d    = head.V_dim;
                    u_last_d  = head.U_dim1;
                    it_last_d = head.ITER_dim1;
                    u_d       = '0;
                    it_d      = '0;
                    rd_addr_d = head.start_rd;
                    wr_addr_d = head.start_wr;
                    if (is_mac) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                rd_addr_d = rd_addr_q + UB_ADDR_W'(1);
                if (u_q == u_last_q) begin
                    u_d = '0;
                    if (it_q == it_last_q) state_d = S_DRAIN;
                    else                   it_d    = it_q + DIM_W'(1);
                end else begin
                    u_d = u_q + DIM_W'(1);
                end
            end
            S_DRAIN: begin
                // The line is fed nothing now, so empty-after-shift marks the last write.
                if (!pending) begin
                    state_d    = S_IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mac_op_q  <= '0;
            cols_q    <= '0;
            u_last_q  <= '0;
            it_last_q <= '0;
            u_q       <= '0;
            it_q      <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mac_op_q  <= mac_op_d;
            cols_q    <= cols_d;
            u_last_q  <= u_last_d;
            it_last_q <= it_last_d;
            u_q       <= u_d;
            it_q      <= it_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            done_q    <= done_d;
        end
    end

    valid_delay_line #(
        .DEPTH (DRAIN_LAT)
    ) u_wb_dl (
        .clk_i       (clk_i),
        .clr_i       (rst_i),
        .valid_i     (issue),
        .valid_o     (wr_en),
        .any_valid_o (pending)
    );

    assign bus.read       = pop & ~rst_i;
    assign bus.busy       = issue | (state_q == S_DRAIN);
    assign bus.mac_op     = mac_op_q;
    assign bus.mac_cols   = cols_q;
    assign bus.ub_rd_en   = issue;
    assign bus.ub_rd_addr = issue ? rd_addr_q : '0;
    assign bus.u_idx      = issue ? u_q : '0;
    assign bus.iter_idx   = issue ? it_q : '0;
    assign bus.ub_wr_en   = wr_en;
    assign bus.ub_wr_addr = wr_en ? wr_addr_q : '0;
    assign bus.instr_done = (done_q | drain_done) & ~rst_i;

endmodule

// File: tb/tb_mac_instruction_sequencer.sv
// Bench for mac_instruction_sequencer: queue model plus per-cycle
// expectations derived from each instruction's beat schedule.
module tb_mac_instruction_sequencer;
    import mac_instruction_sequencer_pkg::*;

    localparam int IQL = 2;
    localparam int DL  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_instruction_sequencer_if bus ();

    mac_instruction_sequencer #(
        .IQ_LAT    (IQL),
        .DRAIN_LAT (DL)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_done = -100;
    int glitch = 0;
    decoded_instr_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic decoded_instr_t mk(input logic [2:0] op,
        input int u, input int it, input int rd, input int wr, input int v);
        decoded_instr_t d;
        d.MAC_op    = op;
        d.U_dim     = DIM_W'(u);
        d.U_dim1    = DIM_W'(u - 1);
        d.ITER_dim  = DIM_W'(it);
        d.ITER_dim1 = DIM_W'(it - 1);
        d.V_dim     = DIM_W'(v);
        d.start_rd  = UB_ADDR_W'(rd);
        d.start_wr  = UB_ADDR_W'(wr);
        return d;
    endfunction

    // Queue head becomes visible IQL cycles after non-empty or after a pop.
    initial begin : iq_model
        int hide;
        logic rd_s;
        logic [95:0] r;
        hide = IQL;
        bus.iq_empty = 1'b1;
        bus.decoded_instruction = '0;
        forever begin
            @(negedge clk);
            rd_s = bus.read;
            @(posedge clk);
            #1;
            r = {$urandom, $urandom, $urandom};
            if (rd_s) begin
                hide = IQL;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (glitch > 0) begin
                glitch--;
                hide = IQL;
                bus.iq_empty = 1'b0;
                bus.decoded_instruction = r[$bits(decoded_instr_t)-1:0];
            end else if (q.size() == 0) begin
                hide = IQL;
                bus.iq_empty = 1'b1;
                bus.decoded_instruction = r[$bits(decoded_instr_t)-1:0];
            end else begin
                bus.iq_empty = 1'b0;
                if (hide > 0) begin
                    hide--;
                    bus.decoded_instruction = r[$bits(decoded_instr_t)-1:0];
                end else begin
                    bus.decoded_instruction = q[0];
                end
            end
        end
    end

    task automatic run(input string nm, input decoded_instr_t ins, input bit push);
        bit mac, found, rd_e, wr_e;
        int n, t, len, j;
        logic [11:0] a;
        mac = (ins.MAC_op == 3'b010) && (ins.U_dim != 0) && (ins.ITER_dim != 0);
        n = mac ? int'(ins.U_dim) * int'(ins.ITER_dim) : 0;
        if (push) begin
            @(negedge clk);
            q.push_back(ins);
        end
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.read) found = 1;
        end
        chk({nm, ".read_seen"}, 32'(found), 1);
        if (!found) return;
        t = cyc;
        chk({nm, ".read_nonempty"}, 32'(bus.iq_empty), 0);
        chk({nm, ".gap"}, 32'((t - last_done) >= IQL), 1);
        len = mac ? n + DL + 1 : 2;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            rd_e = mac && k < n;
            wr_e = mac && k >= DL && (k - DL) < n;
            chk({nm, ".rd_en"}, 32'(bus.ub_rd_en), 32'(rd_e));
            if (rd_e) begin
                a = 12'(int'(ins.start_rd) + k);
                chk({nm, ".rd_addr"}, 32'(bus.ub_rd_addr), 32'(a));
                chk({nm, ".u"}, 32'(bus.u_idx), 32'(k % int'(ins.U_dim)));
                chk({nm, ".iter"}, 32'(bus.iter_idx), 32'(k / int'(ins.U_dim)));
            end
            chk({nm, ".wr_en"}, 32'(bus.ub_wr_en), 32'(wr_e));
            if (wr_e) begin
                j = k - DL;
                a = 12'(int'(ins.start_wr) + j);
                chk({nm, ".wr_addr"}, 32'(bus.ub_wr_addr), 32'(a));
            end
            chk({nm, ".done"}, 32'(bus.instr_done),
                32'(mac ? (k == n + DL - 1) : (k == 0)));
            chk({nm, ".busy"}, 32'(bus.busy), 32'(mac && k < n + DL));
            chk({nm, ".read"}, 32'(bus.read), 0);
            chk({nm, ".mac_op"}, 32'(bus.mac_op), 32'(ins.MAC_op));
            chk({nm, ".cols"}, 32'(bus.mac_cols), 32'(ins.V_dim));
            if (bus.instr_done) last_done = cyc;
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".read"}, 32'(bus.read), 0);
        chk({nm, ".rd_en"}, 32'(bus.ub_rd_en), 0);
        chk({nm, ".wr_en"}, 32'(bus.ub_wr_en), 0);
        chk({nm, ".busy"}, 32'(bus.busy), 0);
        chk({nm, ".done"}, 32'(bus.instr_done), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        decoded_instr_t a, b, c;
        bit found;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset.mac_op", 32'(bus.mac_op), 0);
        chk("reset.cols", 32'(bus.mac_cols), 0);
        chk("reset.rd_addr", 32'(bus.ub_rd_addr), 0);
        chk("reset.wr_addr", 32'(bus.ub_wr_addr), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("empty.read", 32'(bus.read), 0);
            chk("empty.rd_en", 32'(bus.ub_rd_en), 0);
            chk("empty.wr_en", 32'(bus.ub_wr_en), 0);
        end
        glitch = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("glitch.read", 32'(bus.read), 0);
            chk("glitch.busy", 32'(bus.busy), 0);
        end

        run("basic", mk(3'b010, 4, 2, 'h010, 'h200, 16), 1);
        run("wrap", mk(3'b010, 4, 1, 'hFFE, 'hFFE, 3), 1);
        run("noop_op", mk(3'b000, 3, 2, 'h100, 'h300, 5), 1);
        run("noop_u0", mk(3'b010, 0, 3, 'h100, 'h300, 6), 1);
        run("noop_it0", mk(3'b010, 3, 0, 'h100, 'h300, 7), 1);

        a = mk(3'b010, 2, 1, 'h040, 'h400, 2);
        b = mk(3'b010, 2, 1, 'h080, 'h500, 9);
        @(negedge clk);
        q.push_back(a);
        q.push_back(b);
        run("b2b0", a, 0);
        run("b2b1", b, 0);

        for (int i = 0; i < 8; i++) begin
            c = mk(($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b010,
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                   int'($urandom_range(0, 255)));
            run($sformatf("rand%0d", i), c, 1);
        end

        @(negedge clk);
        q.push_back(mk(3'b010, 4, 2, 'h010, 'h200, 4));
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.read) found = 1;
        end
        chk("rst.read_seen", 32'(found), 1);
        repeat (3) @(negedge clk);
        chk("rst.beat3_en", 32'(bus.ub_rd_en), 1);
        chk("rst.beat3_u", 32'(bus.u_idx), 2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("rst_after");
        chk("rst_after.mac_op", 32'(bus.mac_op), 0);
        chk("rst_after.cols", 32'(bus.mac_cols), 0);
        chk("rst_after.rd_addr", 32'(bus.ub_rd_addr), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_idle("rst_quiet");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
